// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   General-purpose register file serving the read stage. Two independent
//   read ports (A, B) return registered data one cycle after the request.
//   One write per cycle is accepted from writeback. A read and a write to the
//   same index in the same cycle return the new data (write-first bypass).
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    register index width; 2**ADDR_W registers
//   ZERO_REG  1: register 0 reads as 0 and ignores writes; 0: ordinary
//
// Ports
//   cpu_clk, cpu_rst          clock, synchronous active-high reset
//   reg_a_read/reg_a          port A request and index
//   reg_a_value               port A data (valid the cycle after request)
//   reg_b_read/reg_b          port B request and index
//   reg_b_value               port B data (valid the cycle after request)
//   wb_en/wb_dst_reg/wb_out   writeback enable, destination, data
//   dbg_reg/dbg_value         combinational peek of stored contents
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              reg_a_read,
    input  logic [ADDR_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_a_value,
    input  logic              reg_b_read,
    input  logic [ADDR_W-1:0] reg_b,
    output logic [DATA_W-1:0] reg_b_value,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dst_reg,
    input  logic [DATA_W-1:0] wb_out,
    input  logic [ADDR_W-1:0] dbg_reg,
    output logic [DATA_W-1:0] dbg_value
);

    localparam int unsigned NREGS = 2 ** ADDR_W;
    localparam bit          ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [NREGS];

    logic              wr_ok;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // A write to register 0 is dropped when it is hard-wired to zero.
    assign wr_ok = wb_en && !(ZR && (wb_dst_reg == '0));

    // Next read data per port: zero register first, then bypass, then storage.
    always_comb begin
        rd_a = regs[reg_a];
        if (ZR && (reg_a == '0)) begin
            rd_a = '0;
        end else if (wr_ok && (wb_dst_reg == reg_a)) begin
            rd_a = wb_out;
        end
    end

    always_comb begin
        rd_b = regs[reg_b];
        if (ZR && (reg_b == '0)) begin
            rd_b = '0;
        end else if (wr_ok && (wb_dst_reg == reg_b)) begin
            rd_b = wb_out;
        end
    end

    // Debug peek shows stored contents only, no bypass.
    always_comb begin
        dbg_value = regs[dbg_reg];
        if (ZR && (dbg_reg == '0)) begin
            dbg_value = '0;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            regs        <= '{default: '0};
            reg_a_value <= '0;
            reg_b_value <= '0;
        end else begin
            if (wr_ok) begin
                regs[wb_dst_reg] <= wb_out;
            end
            if (reg_a_read) begin
                reg_a_value <= rd_a;
            end
            if (reg_b_read) begin
                reg_b_value <= rd_b;
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Directed-vector bench for reg_file (default parameters, ZERO_REG=1).
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_reg_file;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        reg_a_read;
    logic [3:0]  reg_a;
    logic [15:0] reg_a_value;
    logic        reg_b_read;
    logic [3:0]  reg_b;
    logic [15:0] reg_b_value;
    logic        wb_en;
    logic [3:0]  wb_dst_reg;
    logic [15:0] wb_out;
    logic [3:0]  dbg_reg;
    logic [15:0] dbg_value;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    reg_file #(
        .DATA_W   (16),
        .ADDR_W   (4),
        .ZERO_REG (1)
    ) dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst     (cpu_rst),
        .reg_a_read  (reg_a_read),
        .reg_a       (reg_a),
        .reg_a_value (reg_a_value),
        .reg_b_read  (reg_b_read),
        .reg_b       (reg_b),
        .reg_b_value (reg_b_value),
        .wb_en       (wb_en),
        .wb_dst_reg  (wb_dst_reg),
        .wb_out      (wb_out),
        .dbg_reg     (dbg_reg),
        .dbg_value   (dbg_value)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic idle();
        reg_a_read = 1'b0;
        reg_b_read = 1'b0;
        wb_en      = 1'b0;
    endtask

    task automatic wr(input logic [3:0] r, input logic [15:0] v);
        wb_en      = 1'b1;
        wb_dst_reg = r;
        wb_out     = v;
    endtask

    task automatic rd_a(input logic [3:0] r);
        reg_a_read = 1'b1;
        reg_a      = r;
    endtask

    task automatic rd_b(input logic [3:0] r);
        reg_b_read = 1'b1;
        reg_b      = r;
    endtask

    initial begin
        cpu_rst    = 1'b1;
        reg_a      = '0;
        reg_b      = '0;
        wb_dst_reg = '0;
        wb_out     = '0;
        dbg_reg    = '0;
        idle();

        // 1. Reset held two cycles, then every register reads zero on both ports.
        tick();
        tick();
        cpu_rst = 1'b0;
        check("rst_a", reg_a_value, 16'h0000);
        check("rst_b", reg_b_value, 16'h0000);
        for (int i = 1; i < 16; i++) begin
            rd_a(4'(i));
            rd_b(4'(i));
            tick();
            check($sformatf("rst_r%0d_a", i), reg_a_value, 16'h0000);
            check($sformatf("rst_r%0d_b", i), reg_b_value, 16'h0000);
        end
        idle();

        // 2. Write r5, read it next cycle; data appears exactly one cycle later.
        wr(4'd5, 16'hBEEF);
        tick();
        idle();
        rd_a(4'd5);
        #1;
        check("lat_before_edge", reg_a_value, 16'h0000);
        tick();
        idle();
        check("basic_r5", reg_a_value, 16'hBEEF);
        dbg_reg = 4'd5;
        #1;
        check("dbg_r5", dbg_value, 16'hBEEF);

        // 3. Bypass on both ports; debug port still shows the old value.
        wr(4'd7, 16'h1111);
        tick();
        wr(4'd7, 16'h2222);
        rd_a(4'd7);
        rd_b(4'd7);
        dbg_reg = 4'd7;
        #1;
        check("dbg_no_bypass", dbg_value, 16'h1111);
        tick();
        idle();
        check("bypass_a", reg_a_value, 16'h2222);
        check("bypass_b", reg_b_value, 16'h2222);

        // Bypass on one port while the other reads a different index.
        wr(4'd9, 16'h0F0F);
        rd_a(4'd9);
        rd_b(4'd5);
        tick();
        idle();
        check("mixed_a", reg_a_value, 16'h0F0F);
        check("mixed_b", reg_b_value, 16'hBEEF);

        // 4. Zero register ignores writes and reads as zero, including same-cycle.
        wr(4'd0, 16'hFFFF);
        rd_a(4'd0);
        tick();
        idle();
        check("zero_same_cycle", reg_a_value, 16'h0000);
        rd_a(4'd0);
        tick();
        idle();
        check("zero_later", reg_a_value, 16'h0000);
        dbg_reg = 4'd0;
        #1;
        check("dbg_zero", dbg_value, 16'h0000);

        // 5. Hold: output keeps its value until the next read request.
        wr(4'd3, 16'h00A5);
        tick();
        idle();
        rd_a(4'd3);
        tick();
        idle();
        check("hold_first", reg_a_value, 16'h00A5);
        wr(4'd3, 16'h5A00);
        tick();
        idle();
        check("hold_during_wr", reg_a_value, 16'h00A5);
        tick();
        check("hold_idle", reg_a_value, 16'h00A5);
        rd_a(4'd3);
        tick();
        idle();
        check("hold_reread", reg_a_value, 16'h5A00);

        // A request issued just before reset produces no data after reset.
        wr(4'd4, 16'h4444);
        tick();
        idle();
        rd_a(4'd4);
        rd_b(4'd5);
        tick();
        check("pre_rst_a", reg_a_value, 16'h4444);
        check("pre_rst_b", reg_b_value, 16'hBEEF);

        // 6. Reset coinciding with a write and reads: all discarded.
        cpu_rst = 1'b1;
        wr(4'd2, 16'h1234);
        rd_a(4'd2);
        rd_b(4'd5);
        tick();
        cpu_rst = 1'b0;
        idle();
        check("rst_mid_a", reg_a_value, 16'h0000);
        check("rst_mid_b", reg_b_value, 16'h0000);
        rd_a(4'd2);
        rd_b(4'd5);
        tick();
        idle();
        check("after_rst_r2", reg_a_value, 16'h0000);
        check("after_rst_r5", reg_b_value, 16'h0000);
        dbg_reg = 4'd4;
        #1;
        check("after_rst_dbg_r4", dbg_value, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
